// File: rtl/NVP_v1_constants.sv
`default_nettype none
// ============================================================================
// Package     : NVP_v1_constants
// Description : Shared NVP v1 sizing constants for the activation buffer path.
// Revision    : 1.0 - initial release
// ============================================================================
package NVP_v1_constants;
    localparam int ACTIVATION_BUFFER_BANK_COUNT      = 4;
    localparam int ACTIVATION_LINE_BUFFER_DEPTH      = 16;
    localparam int NUMBER_OF_ACTIVATION_LINE_BUFFERS = 6;
    localparam int AXI_BUS_BIT_WIDTH                 = 64;
endpackage
`default_nettype wire

// File: rtl/activation_buffer_write_control.sv
`default_nettype none
// ============================================================================
// Module      : activation_buffer_write_control
// Description : Arbitrates activation line-buffer writes between a streamed
//               writeback frame (full words, ping-pong buffer selection) and
//               single-bank AXI writes. Streamed beats take priority; AXI is
//               back-pressured for that cycle. All write outputs are registered.
//               Optional feature macro: ACTIVATION_WRITE_COLLISION_CHECK_EN
//               (drops AXI writes aimed at the active stream buffer and raises a
//               sticky o_overrun_error).
// Revision    : 1.0 - initial release
// ============================================================================
module activation_buffer_write_control #(
    parameter int ACTIVATION_BUFFER_BANK_COUNT      = NVP_v1_constants::ACTIVATION_BUFFER_BANK_COUNT,
    parameter int ACTIVATION_LINE_BUFFER_DEPTH      = NVP_v1_constants::ACTIVATION_LINE_BUFFER_DEPTH,
    parameter int NUMBER_OF_ACTIVATION_LINE_BUFFERS = NVP_v1_constants::NUMBER_OF_ACTIVATION_LINE_BUFFERS,
    parameter int AXI_BUS_BIT_WIDTH                 = NVP_v1_constants::AXI_BUS_BIT_WIDTH,
    localparam int AW = $clog2(ACTIVATION_LINE_BUFFER_DEPTH),
    localparam int SW = $clog2(NUMBER_OF_ACTIVATION_LINE_BUFFERS),
    localparam int BW = $clog2(ACTIVATION_BUFFER_BANK_COUNT),
    localparam int W  = AXI_BUS_BIT_WIDTH,
    localparam int D  = AXI_BUS_BIT_WIDTH * ACTIVATION_BUFFER_BANK_COUNT,
    localparam int LB = NUMBER_OF_ACTIVATION_LINE_BUFFERS,
    localparam int BANKS = ACTIVATION_BUFFER_BANK_COUNT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_stream_start,
    input  logic [SW-2:0]         i_stream_pair,
    input  logic [AW-1:0]         i_stream_start_address,
    input  logic [AW:0]           i_stream_length,
    input  logic                  i_ping_pong_clear,
    output logic                  o_ping_pong_ptr,
    output logic                  o_stream_busy,
    output logic                  o_stream_done,
    input  logic                  i_stream_valid,
    output logic                  o_stream_ready,
    input  logic [D-1:0]          i_stream_data,
    input  logic                  i_axi_wr_en,
    output logic                  o_axi_wr_ready,
    input  logic [SW+AW+BW-1:0]   i_axi_wr_address,
    input  logic [W-1:0]          i_axi_wr_data,
    output logic [LB-1:0]         o_wr_en,
    output logic [AW-1:0]         o_wr_addr,
    output logic [D-1:0]          o_wr_data,
    output logic [BANKS-1:0]      o_wr_bank_mask,
    output logic                  o_overrun_error
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_writing = 2'd1;
    localparam logic [1:0] c_st_done    = 2'd2;

    localparam int            c_lb_cmp_w  = SW + 1;
    localparam logic [SW:0]   c_lb_count  = c_lb_cmp_w'(LB);
    localparam logic [AW-1:0] c_last_addr = AW'(ACTIVATION_LINE_BUFFER_DEPTH - 1);
    localparam logic [AW-1:0] c_addr_one  = 1;
    localparam logic [AW:0]   c_cnt_one   = 1;
    localparam logic [LB-1:0] c_lb_one    = 1;

    // Frame control state
    logic [1:0]    state_q,  state_d;
    logic [AW:0]   count_q,  count_d;
    logic [AW:0]   len_q,    len_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [SW-1:0] target_q, target_d;
    logic          ptr_q,    ptr_d;

    // Registered write port
    logic [LB-1:0]    wr_en_q,   wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [D-1:0]     wr_data_q, wr_data_d;
    logic [BANKS-1:0] wr_mask_q, wr_mask_d;

    // AXI decode and arbitration
    logic             w_beat_accept;
    logic             w_axi_accept;
    logic [SW-1:0]    w_axi_buf;
    logic [AW-1:0]    w_axi_line;
    logic [BW-1:0]    w_axi_bank;
    logic             w_axi_buf_valid;
    logic             w_collision;
    logic [D-1:0]     w_axi_data_word;
    logic [BANKS-1:0] w_axi_mask;

    assign w_beat_accept   = (state_q == c_st_writing) && i_stream_valid;
    assign w_axi_accept    = i_axi_wr_en && !w_beat_accept;
    assign w_axi_buf       = i_axi_wr_address[SW+AW+BW-1 -: SW];
    assign w_axi_line      = i_axi_wr_address[AW+BW-1 -: AW];
    assign w_axi_bank      = i_axi_wr_address[BW-1:0];
    assign w_axi_buf_valid = ({1'b0, w_axi_buf} < c_lb_count);

    assign o_stream_ready  = (state_q == c_st_writing);
    assign o_stream_busy   = (state_q == c_st_writing) || (state_q == c_st_done);
    assign o_stream_done   = (state_q == c_st_done);
    assign o_ping_pong_ptr = ptr_q;
    assign o_axi_wr_ready  = !w_beat_accept;

    assign o_wr_en         = wr_en_q;
    assign o_wr_addr       = wr_addr_q;
    assign o_wr_data       = wr_data_q;
    assign o_wr_bank_mask  = wr_mask_q;

`ifdef ACTIVATION_WRITE_COLLISION_CHECK_EN
    logic overrun_q, overrun_d;

    // An AXI write into the buffer currently being streamed would be clobbered.
    assign w_collision     = (state_q == c_st_writing) && (w_axi_buf == target_q);
    assign overrun_d       = overrun_q || (w_axi_accept && w_collision);
    assign o_overrun_error = overrun_q;

    // Sticky overrun flag, cleared only by reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end
`else
    assign w_collision     = 1'b0;
    assign o_overrun_error = 1'b0;
`endif

    // Place the AXI bank payload; bank 0 occupies the most significant slice
    always_comb begin
        w_axi_data_word = '0;
        w_axi_mask      = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (w_axi_bank == BW'(b)) begin
                w_axi_data_word[(BANKS-b)*W-1 -: W] = i_axi_wr_data;
                w_axi_mask[BANKS-1-b]               = 1'b1;
            end
        end
    end

    // Frame sequencing: start latch, beat counting with address wrap, ping-pong toggle
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        len_d    = len_q;
        addr_d   = addr_q;
        target_d = target_q;
        ptr_d    = ptr_q;
        case (state_q)
            c_st_idle: begin
                if (i_stream_start) begin
                    len_d    = i_stream_length;
                    addr_d   = i_stream_start_address;
                    count_d  = '0;
                    target_d = {i_stream_pair, ptr_q};
                    state_d  = (i_stream_length == '0) ? c_st_done : c_st_writing;
                end
            end
            c_st_writing: begin
                if (w_beat_accept) begin
                    count_d = count_q + c_cnt_one;
                    addr_d  = (addr_q == c_last_addr) ? '0 : addr_q + c_addr_one;
                    if ((count_q + c_cnt_one) == len_q) begin
                        state_d = c_st_done;
                    end
                end
            end
            c_st_done: begin
                ptr_d   = ~ptr_q;
                state_d = c_st_idle;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
        // Clear wins over the end-of-frame toggle
        if (i_ping_pong_clear) begin
            ptr_d = 1'b0;
        end
    end

    // Select the write issued next cycle: stream beat first, then a legal AXI write
    always_comb begin
        wr_en_d   = '0;
        wr_addr_d = '0;
        wr_data_d = '0;
        wr_mask_d = '0;
        if (w_beat_accept) begin
            wr_en_d   = c_lb_one << target_q;
            wr_addr_d = addr_q;
            wr_data_d = i_stream_data;
            wr_mask_d = '1;
        end else if (w_axi_accept && w_axi_buf_valid && !w_collision) begin
            wr_en_d   = c_lb_one << w_axi_buf;
            wr_addr_d = w_axi_line;
            wr_data_d = w_axi_data_word;
            wr_mask_d = w_axi_mask;
        end
    end

    // Frame control registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= c_st_idle;
            count_q  <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            target_q <= '0;
            ptr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            target_q <= target_d;
            ptr_q    <= ptr_d;
        end
    end

    // Registered write port
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_mask_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_mask_q <= wr_mask_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_activation_buffer_write_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_activation_buffer_write_control
// Description : Self-checking bench for activation_buffer_write_control with a
//               frame-level reference model, directed scenarios and random
//               traffic. Honours ACTIVATION_WRITE_COLLISION_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_activation_buffer_write_control;

    localparam int BANKS = 4;
    localparam int W     = 64;
    localparam int DEPTH = 16;
    localparam int LB    = 6;
    localparam int AW    = 4;
    localparam int SW    = 3;
    localparam int BW    = 2;
    localparam int D     = 256;
    localparam int XW    = SW + AW + BW;

    logic            clk;
    logic            resetn;
    logic            i_stream_start;
    logic [SW-2:0]   i_stream_pair;
    logic [AW-1:0]   i_stream_start_address;
    logic [AW:0]     i_stream_length;
    logic            i_ping_pong_clear;
    logic            o_ping_pong_ptr;
    logic            o_stream_busy;
    logic            o_stream_done;
    logic            i_stream_valid;
    logic            o_stream_ready;
    logic [D-1:0]    i_stream_data;
    logic            i_axi_wr_en;
    logic            o_axi_wr_ready;
    logic [XW-1:0]   i_axi_wr_address;
    logic [W-1:0]    i_axi_wr_data;
    logic [LB-1:0]   o_wr_en;
    logic [AW-1:0]   o_wr_addr;
    logic [D-1:0]    o_wr_data;
    logic [BANKS-1:0] o_wr_bank_mask;
    logic            o_overrun_error;

    activation_buffer_write_control #(
        .ACTIVATION_BUFFER_BANK_COUNT      (BANKS),
        .ACTIVATION_LINE_BUFFER_DEPTH      (DEPTH),
        .NUMBER_OF_ACTIVATION_LINE_BUFFERS (LB),
        .AXI_BUS_BIT_WIDTH                 (W)
    ) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .i_stream_start         (i_stream_start),
        .i_stream_pair          (i_stream_pair),
        .i_stream_start_address (i_stream_start_address),
        .i_stream_length        (i_stream_length),
        .i_ping_pong_clear      (i_ping_pong_clear),
        .o_ping_pong_ptr        (o_ping_pong_ptr),
        .o_stream_busy          (o_stream_busy),
        .o_stream_done          (o_stream_done),
        .i_stream_valid         (i_stream_valid),
        .o_stream_ready         (o_stream_ready),
        .i_stream_data          (i_stream_data),
        .i_axi_wr_en            (i_axi_wr_en),
        .o_axi_wr_ready         (o_axi_wr_ready),
        .i_axi_wr_address       (i_axi_wr_address),
        .i_axi_wr_data          (i_axi_wr_data),
        .o_wr_en                (o_wr_en),
        .o_wr_addr              (o_wr_addr),
        .o_wr_data              (o_wr_data),
        .o_wr_bank_mask         (o_wr_bank_mask),
        .o_overrun_error        (o_overrun_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    bit           m_active;     // frame open, beats still owed
    bit           m_done;       // the one-cycle end-of-frame slot
    bit           m_ptr;
    bit           m_overrun;
    int           m_len;
    int           m_beats;
    int           m_start;
    int           m_target;
    bit           m_wr;
    int           m_wr_buf;
    int           m_wr_addr;
    logic [255:0] m_wr_data;
    logic [3:0]   m_wr_mask;

    task automatic model_reset();
        m_active  = 0;
        m_done    = 0;
        m_ptr     = 0;
        m_overrun = 0;
        m_len     = 0;
        m_beats   = 0;
        m_start   = 0;
        m_target  = 0;
        m_wr      = 0;
        m_wr_buf  = 0;
        m_wr_addr = 0;
        m_wr_data = '0;
        m_wr_mask = '0;
    endtask

    task automatic model_step();
        bit beat;
        bit axi_acc;
        bit collide;
        bit old_active;
        bit old_done;
        bit old_ptr;
        int a;
        int buf_i;
        int line;
        int bank;
        old_active = m_active;
        old_done   = m_done;
        old_ptr    = m_ptr;
        beat       = m_active && i_stream_valid;
        axi_acc    = i_axi_wr_en && !beat;
        m_wr       = 0;
        if (beat) begin
            m_wr      = 1;
            m_wr_buf  = m_target;
            m_wr_addr = (m_start + m_beats) % DEPTH;
            m_wr_data = i_stream_data;
            m_wr_mask = 4'hF;
        end else if (axi_acc) begin
            a       = int'(i_axi_wr_address);
            buf_i   = a / (DEPTH * BANKS);
            line    = (a / BANKS) % DEPTH;
            bank    = a % BANKS;
            collide = 0;
`ifdef ACTIVATION_WRITE_COLLISION_CHECK_EN
            collide = old_active && (buf_i == m_target);
            if (collide) m_overrun = 1;
`endif
            if (buf_i < LB && !collide) begin
                m_wr      = 1;
                m_wr_buf  = buf_i;
                m_wr_addr = line;
                m_wr_data = 256'(i_axi_wr_data) << ((BANKS - 1 - bank) * W);
                m_wr_mask = 4'(1 << (BANKS - 1 - bank));
            end
        end
        if (old_done) begin
            m_ptr  = !m_ptr;
            m_done = 0;
        end
        if (i_ping_pong_clear) m_ptr = 0;
        if (!old_active && !old_done && i_stream_start) begin
            m_target = 2 * int'(i_stream_pair) + int'(old_ptr);
            m_start  = int'(i_stream_start_address);
            m_len    = int'(i_stream_length);
            m_beats  = 0;
            if (m_len == 0) m_done = 1;
            else            m_active = 1;
        end
        if (beat) begin
            m_beats++;
            if (m_beats == m_len) begin
                m_active = 0;
                m_done   = 1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_reset();
            else         model_step();
        end
    end

    // Compare every cycle on the falling edge
    initial begin
        logic [5:0] exp_en;
        forever begin
            @(negedge clk);
            exp_en = m_wr ? 6'(1 << m_wr_buf) : 6'd0;
            check("wr_en", 256'(o_wr_en), 256'(exp_en));
            if (m_wr) begin
                check("wr_addr", 256'(o_wr_addr), 256'(m_wr_addr));
                check("wr_data", o_wr_data, m_wr_data);
                check("wr_mask", 256'(o_wr_bank_mask), 256'(m_wr_mask));
            end
            check("stream_ready", 256'(o_stream_ready), 256'(m_active));
            check("axi_ready", 256'(o_axi_wr_ready), 256'(!(m_active && i_stream_valid)));
            check("busy", 256'(o_stream_busy), 256'(m_active || m_done));
            check("done", 256'(o_stream_done), 256'(m_done));
            check("ptr", 256'(o_ping_pong_ptr), 256'(m_ptr));
            check("overrun", 256'(o_overrun_error), 256'(m_overrun));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic start_frame(input int pair, input int addr, input int len);
        i_stream_start         = 1'b1;
        i_stream_pair          = 2'(pair);
        i_stream_start_address = 4'(addr);
        i_stream_length        = 5'(len);
    endtask

    initial begin
        resetn                 = 1'b0;
        i_stream_start         = 1'b0;
        i_stream_pair          = '0;
        i_stream_start_address = '0;
        i_stream_length        = '0;
        i_ping_pong_clear      = 1'b0;
        i_stream_valid         = 1'b0;
        i_stream_data          = '0;
        i_axi_wr_en            = 1'b0;
        i_axi_wr_address       = '0;
        i_axi_wr_data          = '0;
        tick();
        check("rst_wr_en", 256'(o_wr_en), 256'(0));
        check("rst_axi_ready", 256'(o_axi_wr_ready), 256'(1));
        check("rst_stream_ready", 256'(o_stream_ready), 256'(0));
        tick();
        resetn = 1'b1;
        tick();

        // Frame 1: pair 1, addr 14, len 4 -> buffer 2, addresses wrap 14,15,0,1
        start_frame(1, 14, 4);
        i_stream_valid = 1'b1;
        i_stream_data  = 256'hDEAD_BEEF;
        tick();
        i_stream_start = 1'b0;
        tick();
        check("f1_en", 256'(o_wr_en), 256'(6'b000100));
        check("f1_a0", 256'(o_wr_addr), 256'(14));
        check("f1_data", o_wr_data, 256'hDEAD_BEEF);
        check("f1_mask", 256'(o_wr_bank_mask), 256'(4'b1111));
        i_stream_data = rand256();
        tick();
        check("f1_a1", 256'(o_wr_addr), 256'(15));
        tick();
        check("f1_a2", 256'(o_wr_addr), 256'(0));
        tick();
        check("f1_a3", 256'(o_wr_addr), 256'(1));
        check("f1_done", 256'(o_stream_done), 256'(1));
        check("f1_ptr_before", 256'(o_ping_pong_ptr), 256'(0));
        i_stream_valid = 1'b0;
        tick();
        check("f1_ptr_after", 256'(o_ping_pong_ptr), 256'(1));
        check("f1_done_off", 256'(o_stream_done), 256'(0));

        // Frame 2: same pair, pong buffer 3
        start_frame(1, 0, 2);
        i_stream_valid = 1'b1;
        tick();
        i_stream_start = 1'b0;
        tick();
        check("f2_en", 256'(o_wr_en), 256'(6'b001000));
        tick();
        i_stream_valid = 1'b0;
        tick();
        check("f2_ptr", 256'(o_ping_pong_ptr), 256'(0));

        // Frame 3: clear held across the frame keeps ptr at PING
        start_frame(0, 3, 1);
        i_stream_valid    = 1'b1;
        i_ping_pong_clear = 1'b1;
        tick();
        i_stream_start = 1'b0;
        tick();
        tick();
        check("f3_ptr_clear", 256'(o_ping_pong_ptr), 256'(0));
        i_ping_pong_clear = 1'b0;
        i_stream_valid    = 1'b0;

        // AXI single-bank write {buf=2,line=5,bank=1}
        i_axi_wr_en      = 1'b1;
        i_axi_wr_address = 9'((2 << 6) | (5 << 2) | 1);
        i_axi_wr_data    = 64'hA5;
        tick();
        i_axi_wr_en = 1'b0;
        check("axi_en", 256'(o_wr_en), 256'(6'b000100));
        check("axi_addr", 256'(o_wr_addr), 256'(5));
        check("axi_mask", 256'(o_wr_bank_mask), 256'(4'b0100));
        check("axi_data", o_wr_data, 256'hA5 << 128);

        // Stream beat and AXI write in the same cycle
        start_frame(0, 9, 1);
        tick();
        i_stream_start   = 1'b0;
        i_stream_valid   = 1'b1;
        i_axi_wr_en      = 1'b1;
        i_axi_wr_address = 9'((4 << 6) | (3 << 2) | 0);
        i_axi_wr_data    = 64'h77;
        #1;
        check("col_axi_ready_low", 256'(o_axi_wr_ready), 256'(0));
        tick();
        i_stream_valid = 1'b0;
        check("col_stream_first", 256'(o_wr_en), 256'(6'b000001));
        check("col_stream_addr", 256'(o_wr_addr), 256'(9));
        check("col_axi_ready_high", 256'(o_axi_wr_ready), 256'(1));
        tick();
        i_axi_wr_en = 1'b0;
        check("col_axi_next", 256'(o_wr_en), 256'(6'b010000));
        check("col_axi_mask", 256'(o_wr_bank_mask), 256'(4'b1000));
        check("col_axi_data", o_wr_data, 256'h77 << 192);
        check("col_ptr", 256'(o_ping_pong_ptr), 256'(1));

        // Zero-length frame
        start_frame(2, 0, 0);
        tick();
        i_stream_start = 1'b0;
        check("z_done", 256'(o_stream_done), 256'(1));
        check("z_busy", 256'(o_stream_busy), 256'(1));
        check("z_no_wr", 256'(o_wr_en), 256'(0));
        tick();
        check("z_ptr", 256'(o_ping_pong_ptr), 256'(0));
        check("z_done_off", 256'(o_stream_done), 256'(0));

        // Start while writing is ignored
        start_frame(0, 7, 2);
        tick();
        start_frame(2, 1, 5);
        tick();
        i_stream_start = 1'b0;
        i_stream_valid = 1'b1;
        tick();
        check("ign_en", 256'(o_wr_en), 256'(6'b000001));
        check("ign_addr", 256'(o_wr_addr), 256'(7));
        tick();
        check("ign_addr2", 256'(o_wr_addr), 256'(8));
        i_stream_valid = 1'b0;
        tick();
        tick();
        check("ign_idle", 256'(o_stream_busy), 256'(0));

        // Reset in the middle of a frame
        start_frame(0, 2, 4);
        i_stream_valid = 1'b1;
        tick();
        i_stream_start = 1'b0;
        tick();
        tick();
        resetn = 1'b0;
        #1;
        check("rstm_wr_en", 256'(o_wr_en), 256'(0));
        check("rstm_addr", 256'(o_wr_addr), 256'(0));
        check("rstm_data", o_wr_data, 256'(0));
        check("rstm_mask", 256'(o_wr_bank_mask), 256'(0));
        check("rstm_ptr", 256'(o_ping_pong_ptr), 256'(0));
        check("rstm_busy", 256'(o_stream_busy), 256'(0));
        check("rstm_axi_ready", 256'(o_axi_wr_ready), 256'(1));
        tick();
        resetn         = 1'b1;
        i_stream_valid = 1'b0;
        tick();
        check("rstm_no_done", 256'(o_stream_done), 256'(0));

        // AXI write into the buffer being streamed
        start_frame(0, 0, 2);
        tick();
        i_stream_start   = 1'b0;
        i_axi_wr_en      = 1'b1;
        i_axi_wr_address = 9'((0 << 6) | (2 << 2) | 3);
        i_axi_wr_data    = 64'h5A;
        tick();
        i_axi_wr_en = 1'b0;
`ifdef ACTIVATION_WRITE_COLLISION_CHECK_EN
        check("ovr_dropped", 256'(o_wr_en), 256'(0));
        check("ovr_flag", 256'(o_overrun_error), 256'(1));
        tick();
        check("ovr_sticky", 256'(o_overrun_error), 256'(1));
`else
        check("ovr_written", 256'(o_wr_en), 256'(6'b000001));
        check("ovr_mask", 256'(o_wr_bank_mask), 256'(4'b0001));
        check("ovr_data", o_wr_data, 256'h5A);
        check("ovr_none", 256'(o_overrun_error), 256'(0));
        tick();
`endif
        i_stream_valid = 1'b1;
        tick();
        tick();
        i_stream_valid = 1'b0;
        tick();
        tick();

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            i_stream_start         = ($urandom_range(0, 7) == 0);
            i_stream_pair          = 2'($urandom_range(0, 2));
            i_stream_start_address = 4'($urandom_range(0, 15));
            i_stream_length        = 5'($urandom_range(0, 16));
            i_ping_pong_clear      = ($urandom_range(0, 29) == 0);
            i_stream_valid         = ($urandom_range(0, 3) != 0);
            i_stream_data          = rand256();
            i_axi_wr_en            = ($urandom_range(0, 2) == 0);
            i_axi_wr_address       = 9'($urandom_range(0, 511));
            i_axi_wr_data          = {$urandom, $urandom};
            resetn                 = ($urandom_range(0, 499) != 0);
            tick();
        end
        resetn = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
